// File: rtl/pe_pkg.sv
// pe_pkg: shared definitions for the PE feeder.
//   state_t  - sequencer states (IDLE, START, FIL, IFM, FIN)
//   TAG_*    - {first,last} tag values prepended to IFM words
//   ifm_tag  - builds the tag for one IFM word from its position flags
package pe_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    FIL   = 3'd2,
    IFM   = 3'd3,
    FIN   = 3'd4
  } state_t;

  localparam logic [1:0] TAG_FIRST = 2'b10;
  localparam logic [1:0] TAG_LAST  = 2'b01;
  localparam logic [1:0] TAG_MID   = 2'b00;
  localparam logic [1:0] TAG_ONLY  = 2'b11;

  function automatic logic [1:0] ifm_tag(input logic is_first, input logic is_last);
    logic [1:0] tag;
    case ({is_first, is_last})
      2'b11:   tag = TAG_ONLY;
      2'b10:   tag = TAG_FIRST;
      2'b01:   tag = TAG_LAST;
      default: tag = TAG_MID;
    endcase
    return tag;
  endfunction

endpackage

// File: rtl/pe_out_reg.sv
// pe_out_reg: single-entry valid/ready holding register for one PE write port.
// Ports:
//   clk, rst    - clock, synchronous active-high reset (clears entry and data)
//   i_load      - capture i_data this cycle (caller only loads when o_room=1)
//   i_data      - word to capture
//   i_ready     - downstream accepts the held word this cycle
//   o_valid     - a word is held (write enable to the PE)
//   o_data      - held word, stable while o_valid=1 and i_ready=0
//   o_room      - entry can take a new word this cycle (empty or draining)
module pe_out_reg
  import pe_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_room
);

  logic         r_vld_p0;
  logic [W-1:0] r_data_p0;

  // ---- stage p0: holding register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p0  <= 1'b0;
      r_data_p0 <= '0;
    end else if (i_load) begin
      r_vld_p0  <= 1'b1;
      r_data_p0 <= i_data;
    end else if (i_ready) begin
      r_vld_p0  <= 1'b0;
    end
  end

  assign o_valid = r_vld_p0;
  assign o_data  = r_data_p0;
  // A load in the same cycle as a drain keeps full throughput.
  assign o_room  = !r_vld_p0 || i_ready;

endmodule

// File: rtl/pe_feeder.sv
// pe_feeder: sequences one PE load: a start pulse, fil_len filter words, then
// ifm_len IFM words tagged {first,last}, then a one-cycle done.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   go                            - one-cycle start request (ignored while busy)
//   fil_len, ifm_len              - word counts, latched on an accepted go
//   src_valid/src_data/src_ready  - upstream word stream
//   pe_start                      - one-cycle start pulse to the PE
//   w_en_fil/data_fil/ready_fil   - PE filter write port
//   w_en_ifm/data_ifm/ready_ifm   - PE IFM write port, data = {first,last,word}
//   busy, done                    - sequence status
module pe_feeder
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int F          = 4,
  parameter int LEN_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic [F-1:0]          fil_len,
  input  logic [LEN_W-1:0]      ifm_len,
  input  logic                  src_valid,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  src_ready,
  output logic                  pe_start,
  output logic                  w_en_fil,
  output logic [DATA_WIDTH-1:0] data_fil,
  input  logic                  ready_fil,
  output logic                  w_en_ifm,
  output logic [DATA_WIDTH+1:0] data_ifm,
  input  logic                  ready_ifm,
  output logic                  busy,
  output logic                  done
);

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  state_t           r_state;
  state_t           w_next;
  logic [F-1:0]     r_fil_len;
  logic [LEN_W-1:0] r_ifm_len;
  logic [LEN_W-1:0] r_acc_cnt;
  logic [LEN_W-1:0] r_xfr_cnt;

  logic [LEN_W-1:0]      w_fil_len_ext;
  logic [LEN_W-1:0]      w_cur_len;
  logic                  w_in_fil;
  logic                  w_in_ifm;
  logic                  w_more_to_acc;
  logic                  w_fil_room;
  logic                  w_ifm_room;
  logic                  w_room;
  logic                  w_accept;
  logic                  w_fil_load;
  logic                  w_ifm_load;
  logic                  w_xfr;
  logic                  w_last_xfr;
  logic [1:0]            w_tag;
  logic [DATA_WIDTH+1:0] w_ifm_word;

  assign w_fil_len_ext = LEN_W'(r_fil_len);
  assign w_in_fil      = (r_state == FIL);
  assign w_in_ifm      = (r_state == IFM);
  assign w_cur_len     = w_in_fil ? w_fil_len_ext : r_ifm_len;

  // Accepted words never exceed the latched length, so the output register
  // is always empty by the time the last transfer leaves the state.
  assign w_more_to_acc = (r_acc_cnt < w_cur_len);
  assign w_room        = w_in_fil ? w_fil_room : w_ifm_room;
  assign src_ready     = !rst && (w_in_fil || w_in_ifm) && w_more_to_acc && w_room;
  assign w_accept      = src_valid && src_ready;
  assign w_fil_load    = w_accept && w_in_fil;
  assign w_ifm_load    = w_accept && w_in_ifm;

  assign w_xfr      = (w_in_fil && w_en_fil && ready_fil) ||
                      (w_in_ifm && w_en_ifm && ready_ifm);
  assign w_last_xfr = w_xfr && (r_xfr_cnt == (w_cur_len - ONE));

  // Tag is decided at accept time from the accept count.
  assign w_tag      = ifm_tag(r_acc_cnt == '0, r_acc_cnt == (r_ifm_len - ONE));
  assign w_ifm_word = {w_tag, src_data};

  pe_out_reg #(.W(DATA_WIDTH)) u_fil_reg (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_fil_load),
    .i_data  (src_data),
    .i_ready (ready_fil),
    .o_valid (w_en_fil),
    .o_data  (data_fil),
    .o_room  (w_fil_room)
  );

  pe_out_reg #(.W(DATA_WIDTH + 2)) u_ifm_reg (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_ifm_load),
    .i_data  (w_ifm_word),
    .i_ready (ready_ifm),
    .o_valid (w_en_ifm),
    .o_data  (data_ifm),
    .o_room  (w_ifm_room)
  );

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    pe_start = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (go) w_next = START;
      end
      START: begin
        pe_start = 1'b1;
        if (r_fil_len != '0)      w_next = FIL;
        else if (r_ifm_len != '0) w_next = IFM;
        else                      w_next = FIN;
      end
      FIL: begin
        if (w_last_xfr) w_next = (r_ifm_len != '0) ? IFM : FIN;
      end
      IFM: begin
        if (w_last_xfr) w_next = FIN;
      end
      FIN: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: begin
        busy   = 1'b0;
        w_next = IDLE;
      end
    endcase
  end

  // ---- lengths and counters ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fil_len <= '0;
      r_ifm_len <= '0;
      r_acc_cnt <= '0;
      r_xfr_cnt <= '0;
    end else if ((r_state == IDLE) && go) begin
      r_fil_len <= fil_len;
      r_ifm_len <= ifm_len;
      r_acc_cnt <= '0;
      r_xfr_cnt <= '0;
    end else if (w_last_xfr) begin
      // Phase finished: restart both counts for the next phase.
      r_acc_cnt <= '0;
      r_xfr_cnt <= '0;
    end else begin
      if (w_accept) r_acc_cnt <= r_acc_cnt + ONE;
      if (w_xfr)    r_xfr_cnt <= r_xfr_cnt + ONE;
    end
  end

endmodule

// File: tb/tb_pe_feeder.sv
module tb_pe_feeder;

  localparam int DW = 16;
  localparam int FW = 4;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          go = 1'b0;
  logic [FW-1:0] fil_len = '0;
  logic [LW-1:0] ifm_len = '0;
  logic          src_valid = 1'b0;
  logic [DW-1:0] src_data = '0;
  logic          src_ready;
  logic          pe_start;
  logic          w_en_fil;
  logic [DW-1:0] data_fil;
  logic          ready_fil = 1'b1;
  logic          w_en_ifm;
  logic [DW+1:0] data_ifm;
  logic          ready_ifm = 1'b1;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  pe_feeder #(.DATA_WIDTH(DW), .F(FW), .LEN_W(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .go        (go),
    .fil_len   (fil_len),
    .ifm_len   (ifm_len),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_ready (src_ready),
    .pe_start  (pe_start),
    .w_en_fil  (w_en_fil),
    .data_fil  (data_fil),
    .ready_fil (ready_fil),
    .w_en_ifm  (w_en_ifm),
    .data_ifm  (data_ifm),
    .ready_ifm (ready_ifm),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    logic          kind;   // 0 = filter port, 1 = IFM port
    logic [DW+1:0] data;
  } exp_t;

  typedef struct {
    int fl;
    int il;
    bit rf;
    bit ri;
    bit xg;
    int exp_fw;
    int exp_iw;
    int exp_done;
  } vec_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  int   start_cnt = 0;
  int   done_cnt = 0;
  int   fil_wr = 0;
  int   ifm_wr = 0;
  int   src_idx = 0;
  bit   acc_flag = 1'b0;
  bit   rnd_fil = 1'b0;
  bit   rnd_ifm = 1'b0;
  bit   stall_fil = 1'b0;
  bit   stall_ifm = 1'b0;
  logic [DW-1:0] hold_fil = '0;
  logic [DW+1:0] hold_ifm = '0;

  function automatic logic [DW-1:0] src_word(input int k);
    return DW'(k * 263 + 15450);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Source and ready driver: updates inputs just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (acc_flag) src_idx++;
      src_data  = src_word(src_idx);
      ready_fil = rnd_fil ? ($urandom_range(0, 1) == 1) : 1'b1;
      ready_ifm = rnd_ifm ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Monitor / scoreboard: samples mid-cycle, on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        acc_flag  = 1'b0;
        stall_fil = 1'b0;
        stall_ifm = 1'b0;
      end else begin
        acc_flag = src_valid && src_ready;
        if (pe_start) start_cnt++;
        if (done) done_cnt++;
        if (w_en_fil || w_en_ifm) check("wen_exclusive", 32'(w_en_fil & w_en_ifm), 0);
        if (stall_fil) begin
          check("fil_hold_wen", 32'(w_en_fil), 1);
          check("fil_hold_data", 32'(data_fil), 32'(hold_fil));
        end
        if (stall_ifm) begin
          check("ifm_hold_wen", 32'(w_en_ifm), 1);
          check("ifm_hold_data", 32'(data_ifm), 32'(hold_ifm));
        end
        if (w_en_fil && ready_fil) begin
          fil_wr++;
          check("fil_expected", 32'(sbq.size() > 0), 1);
          if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("fil_order_kind", 32'(e.kind), 0);
            check("fil_data", 32'(data_fil), 32'(e.data[DW-1:0]));
          end
        end
        if (w_en_ifm && ready_ifm) begin
          ifm_wr++;
          check("ifm_expected", 32'(sbq.size() > 0), 1);
          if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("ifm_order_kind", 32'(e.kind), 1);
            check("ifm_data_tag", 32'(data_ifm), 32'(e.data));
          end
        end
        stall_fil = w_en_fil && !ready_fil;
        stall_ifm = w_en_ifm && !ready_ifm;
        hold_fil  = data_fil;
        hold_ifm  = data_ifm;
      end
    end
  end

  task automatic load_expect(input int fl, input int il);
    int   base;
    exp_t e;
    base = src_idx;
    sbq.delete();
    for (int j = 0; j < fl; j++) begin
      e.kind = 1'b0;
      e.data = {2'b00, src_word(base + j)};
      sbq.push_back(e);
    end
    for (int j = 0; j < il; j++) begin
      e.kind = 1'b1;
      e.data = {(j == 0), (j == il - 1), src_word(base + fl + j)};
      sbq.push_back(e);
    end
    start_cnt = 0;
    done_cnt  = 0;
    fil_wr    = 0;
    ifm_wr    = 0;
  endtask

  task automatic pulse_go(input int fl, input int il);
    @(posedge clk);
    #1;
    fil_len = FW'(fl);
    ifm_len = LW'(il);
    go      = 1'b1;
    @(posedge clk);
    #1;
    go      = 1'b0;
    // Scramble the length inputs to show they were latched.
    fil_len = '1;
    ifm_len = '1;
  endtask

  task automatic run_seq(input vec_t v, input string tag);
    int waited;
    rnd_fil = v.rf;
    rnd_ifm = v.ri;
    load_expect(v.fl, v.il);
    pulse_go(v.fl, v.il);
    @(negedge clk);
    check({tag, "_pe_start"}, 32'(pe_start), 1);
    check({tag, "_busy"}, 32'(busy), 1);
    if (v.xg) begin
      repeat (3) @(posedge clk);
      #1;
      fil_len = FW'(3);
      ifm_len = LW'(2);
      go      = 1'b1;
      @(posedge clk);
      #1;
      go      = 1'b0;
    end
    waited = 0;
    while (done_cnt == 0 && waited < 3000) begin
      @(posedge clk);
      waited++;
    end
    repeat (20) @(negedge clk);
    check({tag, "_done_count"}, 32'(done_cnt), 32'(v.exp_done));
    check({tag, "_start_count"}, 32'(start_cnt), 1);
    check({tag, "_fil_writes"}, 32'(fil_wr), 32'(v.exp_fw));
    check({tag, "_ifm_writes"}, 32'(ifm_wr), 32'(v.exp_iw));
    check({tag, "_queue_empty"}, 32'(sbq.size()), 0);
    check({tag, "_idle_busy"}, 32'(busy), 0);
    rnd_fil = 1'b0;
    rnd_ifm = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pe_start"}, 32'(pe_start), 0);
    check({tag, "_w_en_fil"}, 32'(w_en_fil), 0);
    check({tag, "_w_en_ifm"}, 32'(w_en_ifm), 0);
    check({tag, "_src_ready"}, 32'(src_ready), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_data_fil"}, 32'(data_fil), 0);
    check({tag, "_data_ifm"}, 32'(data_ifm), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    vec_t v;
    int   waited;

    tbl[0] = '{fl: 6,  il: 10, rf: 0, ri: 0, xg: 0, exp_fw: 6,  exp_iw: 10, exp_done: 1};
    tbl[1] = '{fl: 6,  il: 10, rf: 0, ri: 1, xg: 0, exp_fw: 6,  exp_iw: 10, exp_done: 1};
    tbl[2] = '{fl: 0,  il: 1,  rf: 0, ri: 0, xg: 0, exp_fw: 0,  exp_iw: 1,  exp_done: 1};
    tbl[3] = '{fl: 6,  il: 10, rf: 0, ri: 0, xg: 1, exp_fw: 6,  exp_iw: 10, exp_done: 1};
    tbl[4] = '{fl: 3,  il: 0,  rf: 1, ri: 0, xg: 0, exp_fw: 3,  exp_iw: 0,  exp_done: 1};
    tbl[5] = '{fl: 15, il: 20, rf: 1, ri: 1, xg: 0, exp_fw: 15, exp_iw: 20, exp_done: 1};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst       = 1'b0;
    src_valid = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_seq(tbl[i], $sformatf("vec%0d", i));
    end

    // Zero lengths: START then FIN, done two cycles after go.
    load_expect(0, 0);
    @(posedge clk);
    #1;
    fil_len = '0;
    ifm_len = '0;
    go      = 1'b1;
    @(negedge clk);
    check("zero_go_cycle_busy", 32'(busy), 0);
    @(posedge clk);
    #1;
    go = 1'b0;
    @(negedge clk);
    check("zero_pe_start", 32'(pe_start), 1);
    check("zero_done_early", 32'(done), 0);
    @(negedge clk);
    check("zero_done", 32'(done), 1);
    @(negedge clk);
    check("zero_done_once", 32'(done), 0);
    check("zero_idle", 32'(busy), 0);
    check("zero_writes", 32'(fil_wr + ifm_wr), 0);

    // Reset after the third IFM write, then a fresh replay.
    load_expect(2, 8);
    pulse_go(2, 8);
    waited = 0;
    while (ifm_wr < 3 && waited < 500) begin
      @(posedge clk);
      waited++;
    end
    check("rst_reached_third_write", 32'(ifm_wr >= 3), 1);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    sbq.delete();
    v = '{fl: 2, il: 8, rf: 0, ri: 1, xg: 0, exp_fw: 2, exp_iw: 8, exp_done: 1};
    run_seq(v, "replay");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
